// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
// Holds the gate FSM state encoding and the phase-length helper.
package freq_meter_pkg;

    localparam int BCD_W          = 24;
    localparam int DEFAULT_CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        GATE   = 2'd1,
        SETTLE = 2'd2,
        LATCH  = 2'd3
    } gate_state_e;

    // Timer reload value (phase length minus one) for the phase being entered.
    function automatic logic [31:0] phase_load(input gate_state_e st,
                                               input logic [31:0] clr_n,
                                               input logic [31:0] gate_n,
                                               input logic [31:0] settle_n);
        logic [31:0] len;
        len = 32'd1;
        case (st)
            CLEAR:   len = clr_n;
            GATE:    len = gate_n;
            SETTLE:  len = settle_n;
            default: len = 32'd1;
        endcase
        return len - 32'd1;
    endfunction

endpackage

// File: rtl/freq_gate_timer.sv
// Phase timer: 32-bit down-counter, reloaded on load, done while it sits at zero.
// Latency: done is combinational from the count; no backpressure.
// Reset loads RST_VAL so the first phase after reset runs its full length.
module freq_gate_timer #(
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic        core_clk,
    input  logic        arst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        done
);

    logic [31:0] cnt_q;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    assign done = (cnt_q == 32'd0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate controller for a pulse counter: CLEAR -> GATE -> SETTLE -> LATCH, free running.
// Latency: DISP/VALID update one edge after the LATCH cycle; no backpressure (free running).
// Optional FREQ_GATE_HOLD_EN adds a HOLD input that suppresses the LATCH update.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CLR_CYCLES    = 4,
    parameter int GATE_CYCLES   = DEFAULT_CLK_HZ,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [BCD_W-1:0] Q_IN,
`ifdef FREQ_GATE_HOLD_EN
    input  logic             HOLD,
`endif
    output logic             ENA,
    output logic             CLR,
    output logic [BCD_W-1:0] DISP,
    output logic             VALID
);

    localparam logic [31:0] CLR_N    = 32'(CLR_CYCLES);
    localparam logic [31:0] GATE_N   = 32'(GATE_CYCLES);
    localparam logic [31:0] SETTLE_N = 32'(SETTLE_CYCLES);

    gate_state_e state_q;
    gate_state_e nxt_state;
    logic        tmr_done;
    logic [31:0] tmr_load_val;
    logic        freeze;
    logic        latch_upd;

`ifdef FREQ_GATE_HOLD_EN
    assign freeze = HOLD;
`else
    assign freeze = 1'b0;
`endif

    always_comb begin
        nxt_state = state_q;
        if (tmr_done) begin
            case (state_q)
                CLEAR:   nxt_state = GATE;
                GATE:    nxt_state = SETTLE;
                SETTLE:  nxt_state = LATCH;
                default: nxt_state = CLEAR;
            endcase
        end
    end

    // The timer reloads on every phase change, i.e. whenever it reaches zero.
    assign tmr_load_val = phase_load(nxt_state, CLR_N, GATE_N, SETTLE_N);
    assign latch_upd    = (state_q == LATCH) && tmr_done && !freeze;

    freq_gate_timer #(
        .RST_VAL (CLR_N - 32'd1)
    ) u_timer (
        .core_clk (CLK),
        .arst_n   (RST_N),
        .load     (tmr_done),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // ENA/CLR decode the next state so they are registered and mutually exclusive.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLEAR;
            ENA     <= 1'b0;
            CLR     <= 1'b1;
            DISP    <= '0;
            VALID   <= 1'b0;
        end else begin
            state_q <= nxt_state;
            ENA     <= (nxt_state == GATE);
            CLR     <= (nxt_state == CLEAR);
            VALID   <= latch_upd;
            if (latch_upd) begin
                DISP <= Q_IN;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl (CLR=2, GATE=10, SETTLE=3 => 16-cycle period).
// Expected readings are queued at the LATCH cycle and compared when VALID rises.
module tb_freq_gate_ctrl;

    localparam int PERIOD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] q_in;
    logic [23:0] q_stim;
    logic        hold;
    logic        ena, clr, valid;
    logic [23:0] disp;

    logic        cnt_mode;
    logic        f_in = 1'b0;
    logic [23:0] pc_cnt = 24'h0;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          pos    = 0;
    logic        valid_exp = 1'b0;
    logic [23:0] last_disp = 24'h0;
    logic [23:0] sb[$];

    always #5 clk = ~clk;

    freq_gate_ctrl #(
        .CLR_CYCLES    (2),
        .GATE_CYCLES   (10),
        .SETTLE_CYCLES (3)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .Q_IN  (q_in),
`ifdef FREQ_GATE_HOLD_EN
        .HOLD  (hold),
`endif
        .ENA   (ena),
        .CLR   (clr),
        .DISP  (disp),
        .VALID (valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Pulse counter model: F_IN = CLK/2, edges placed on CLK falling edges.
    always @(negedge clk) f_in <= ~f_in;
    always @(posedge f_in) begin
        if (clr)      pc_cnt <= 24'h0;
        else if (ena) pc_cnt <= bcd_inc(pc_cnt);
    end

    assign q_in = cnt_mode ? pc_cnt : q_stim;

    // Monitor: pos is the cycle index within the period since reset release.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_clr", clr, 1);
            chk("rst_ena", ena, 0);
            chk("rst_valid", valid, 0);
            chk("rst_disp", disp, 0);
            pos       = 0;
            valid_exp = 1'b0;
            last_disp = 24'h0;
            sb.delete();
        end else begin
            chk("ena_phase", ena, (pos >= 2 && pos < 12) ? 1 : 0);
            chk("clr_phase", clr, (pos < 2) ? 1 : 0);
            chk("ena_clr_excl", ena & clr, 0);
            chk("valid_timing", valid, valid_exp);
            if (valid) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("disp_value", disp, sb.pop_front());
                last_disp = disp;
            end else begin
                chk("disp_hold", disp, last_disp);
            end
            valid_exp = 1'b0;
            if (pos == PERIOD - 1 && !hold) begin
                sb.push_back(cnt_mode ? 24'h000005 : q_stim);
                valid_exp = 1'b1;
            end
            pos = (pos == PERIOD - 1) ? 0 : pos + 1;
        end
    end

    task automatic wait_pos(input int target);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 3 * PERIOD && !hit; n++) begin
            @(posedge clk);
            #1;
            if (pos == target) hit = 1'b1;
        end
        if (!hit) chk("wait_timeout", 0, 1);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        q_stim   = 24'h0;
        hold     = 1'b0;
        cnt_mode = 1'b0;
        run_cycles(3);
        chk("rst_direct_clr", clr, 1);

        // Release away from the edge; first full period with Q_IN=0.
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_pos(1);

        // Second period: abort mid-GATE (GATE cycle 5) with a new value pending.
        q_stim = 24'h000999;
        wait_pos(6);
        chk("pre_abort_ena", ena, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ena", ena, 0);
        chk("abort_clr", clr, 1);
        chk("abort_valid", valid, 0);
        chk("abort_disp_keep", disp, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_cycles(PERIOD + 2);
        chk("after_abort_disp", disp, 24'h000999);

        // Constant input across two periods.
        q_stim = 24'h012345;
        run_cycles(2 * PERIOD);
        chk("const_disp", disp, 24'h012345);

`ifdef FREQ_GATE_HOLD_EN
        wait_pos(15);
        q_stim = 24'h000777;
        hold   = 1'b1;
        @(posedge clk);
        #1 hold = 1'b0;
        chk("hold_valid", valid, 0);
        chk("hold_disp", disp, 24'h012345);
        wait_pos(0);
        chk("hold_release_valid", valid, 1);
        chk("hold_release_disp", disp, 24'h000777);
`endif

        // Input toggling during GATE, stable from SETTLE onward.
        wait_pos(1);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < PERIOD; c++) begin
                if (pos >= 2 && pos < 12) q_stim = 24'($urandom);
                else                      q_stim = (p == 0) ? 24'h054321 : 24'h000042;
                @(posedge clk);
                #1;
            end
        end
        chk("changing_disp", disp, 24'h000042);

        // Pulse counter attached: expect 5 counts per gate.
        wait_pos(1);
        cnt_mode = 1'b1;
        run_cycles(3 * PERIOD);
        chk("counter_disp", disp, 24'h000005);

        run_cycles(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 Parameter CLR_CYCLES, default 4: number of CLK cycles CLR is held high per measurement; must be at least 1 and cover at least one F_IN period.
REQ-002 Parameter GATE_CYCLES, default 50_000_000: number of CLK cycles ENA is held high per measurement (1 s at 50 MHz); must be at least 1.
REQ-003 Parameter SETTLE_CYCLES, default 4: number of CLK cycles between ENA falling and the latch, letting the F_IN-domain count settle; must be at least 1.
REQ-004 Port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port Q_IN, input, 24 bits: 6-digit BCD count from the downstream pulse counter, [23:20] most significant digit.
REQ-007 Port HOLD, input, 1 bit: display freeze; present only when FREQ_GATE_HOLD_EN is defined.
REQ-008 Port ENA, output, 1 bit: count-enable to the pulse counter.
REQ-009 Port CLR, output, 1 bit: synchronous clear request to the pulse counter.
REQ-010 Port DISP, output, 24 bits: last latched BCD reading, in Hz.
REQ-011 Port VALID, output, 1 bit: one-cycle pulse marking that DISP holds a new reading.

Function
REQ-012 The FSM SHALL cycle CLEAR -> GATE -> SETTLE -> LATCH -> CLEAR indefinitely, with no idle state.
- CLEAR: CLR=1, ENA=0, for exactly CLR_CYCLES cycles.
- GATE: CLR=0, ENA=1, for exactly GATE_CYCLES cycles.
- SETTLE: CLR=0, ENA=0, for exactly SETTLE_CYCLES cycles.
- LATCH: CLR=0, ENA=0, for 1 cycle.
REQ-013 ENA and CLR SHALL be registered outputs that are never high in the same cycle.
REQ-014 In the LATCH cycle, Q_IN SHALL be sampled so that DISP takes the new value on the next clock edge, with VALID high for exactly that one cycle.
REQ-015 The measurement period SHALL be exactly CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles.
REQ-016 The phase timer SHALL be a single down-counter, 32 bits wide, loaded with N-1 on phase entry; the phase SHALL advance when the counter reaches 0.
REQ-017 DISP SHALL hold its value in every state except the LATCH update.
REQ-018 Q_IN SHALL be latched unmodified; no BCD validation or wrap correction is done in this block.

Reset
REQ-019 While RST_N=0, outputs SHALL be CLR=1, ENA=0, DISP=24'h000000, VALID=0, with state CLEAR and the timer loaded for CLEAR.
REQ-020 RST_N falling mid-phase SHALL abort the phase immediately with no latch.
REQ-021 After RST_N rises, a full CLEAR phase SHALL start on the first CLK edge.

Configuration
REQ-022 With FREQ_GATE_HOLD_EN defined: when HOLD=1 during the LATCH cycle, DISP SHALL be unchanged and VALID SHALL stay 0.
- The FSM SHALL still sequence normally regardless of HOLD.
- HOLD SHALL have no effect in any other state.
REQ-023 Without FREQ_GATE_HOLD_EN, the HOLD port SHALL be absent and every LATCH SHALL update DISP.

Structure
REQ-024 Package freq_meter_pkg SHALL hold:
- the FSM state enum (CLEAR, GATE, SETTLE, LATCH);
- constant BCD_W=24;
- constant DEFAULT_CLK_HZ=50_000_000.
REQ-025 The phase timer SHALL be a sub-module named freq_gate_timer, with ports load, load_val, done.

Verification (CLR_CYCLES=2, GATE_CYCLES=10, SETTLE_CYCLES=3)
REQ-026 The bench SHALL cover the following directed scenarios:
- Reset release, Q_IN=0 -> CLR high for 2 cycles, ENA high for 10, low for 3; VALID pulses at cycle 16 with DISP=000000; period 16.
- Q_IN=24'h012345 held constant -> after the first VALID, DISP=24'h012345; DISP unchanged between VALID pulses.
- Pulse counter attached, F_IN = CLK/2 -> DISP=24'h000005 on each VALID; ENA and CLR never both high.
- RST_N pulsed low at GATE cycle 5 -> ENA=0 and CLR=1 at once, DISP keeps its prior value, no VALID; the next period is a full 16 cycles.
- FREQ_GATE_HOLD_EN defined, HOLD=1 over one LATCH with Q_IN=24'h000777 (previous DISP=24'h012345) -> DISP stays 24'h012345, VALID=0; the next LATCH with HOLD=0 gives DISP=24'h000777.
- Q_IN changing during GATE, stable from SETTLE onward -> DISP equals the value present in the LATCH cycle.
